// File: rtl/kypd_pkg.sv
// Shared constants for the PmodKYPD scan controller: column strobe patterns,
// key legend lookup and default timing parameters.
package kypd_pkg;

   localparam int DEF_COL_CYC         = 100000;
   localparam int DEF_SETTLE_CYC      = 8;
   localparam int DEF_DEBOUNCE_FRAMES = 4;

   typedef enum logic [1:0] {
      COL0 = 2'd0,
      COL1 = 2'd1,
      COL2 = 2'd2,
      COL3 = 2'd3
   } col_state_t;

   // Active-low one-hot column drive, indexed by column number
   localparam logic [3:0] COL_PAT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   // Legend by key index col*4+row, row 0 being R1
   localparam logic [3:0] KEY_LEGEND [16] = '{
      4'h1, 4'h4, 4'h7, 4'h0,
      4'h2, 4'h5, 4'h8, 4'hF,
      4'h3, 4'h6, 4'h9, 4'hE,
      4'hA, 4'hB, 4'hC, 4'hD
   };

endpackage

// File: rtl/kypd_frame_debounce.sv
// Frame-level debounce: the stable key map follows the scanned frame only after
// DEBOUNCE_FRAMES identical frames in a row; upd marks the cycle the map is refreshed.
module kypd_frame_debounce
   import kypd_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        frame_done,
   input  logic [15:0] frame,
   output logic [15:0] key_map,
   output logic        upd
);

   localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_FRAMES);

   logic [15:0] r_prev;
   logic [3:0]  r_stable;
   logic [15:0] r_map;
   logic        r_upd;
   logic [3:0]  w_stable_nxt;

   always_comb begin
      w_stable_nxt = 4'd1;
      if (frame == r_prev) begin
         w_stable_nxt = (r_stable >= DB_MAX) ? DB_MAX : r_stable + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev   <= '0;
         r_stable <= '0;
         r_map    <= '0;
         r_upd    <= 1'b0;
      end else if (clr) begin
         r_prev   <= '0;
         r_stable <= '0;
         r_map    <= '0;
         r_upd    <= 1'b0;
      end else begin
         r_upd <= 1'b0;
         if (frame_done) begin
            r_prev   <= frame;
            r_stable <= w_stable_nxt;
            if (w_stable_nxt == DB_MAX) begin
               r_map <= frame;
               r_upd <= 1'b1;
            end
         end
      end
   end

   assign key_map = r_map;
   assign upd     = r_upd;

endmodule

// File: rtl/kypd_scan_ctrl.sv
// PmodKYPD scan controller: strobes columns, samples synchronized rows after a
// settle delay, debounces whole frames and emits one key event per cycle.
module kypd_scan_ctrl
   import kypd_pkg::*;
#(
   parameter int COL_CYC         = DEF_COL_CYC,
   parameter int SETTLE_CYC      = DEF_SETTLE_CYC,
   parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [3:0]  Row,
   output logic [3:0]  Col,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [15:0] key_map,
   output logic        key_down
);

   localparam int               CNT_W    = $clog2(COL_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COL_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SMP  = CNT_W'(SETTLE_CYC);

   logic [3:0]       r_row_s1, r_row_s2;
   logic [CNT_W-1:0] r_cnt;
   col_state_t       r_col, w_col_nxt;
   logic [3:0]       w_col_drive;
   logic [3:0]       w_rows;
   logic             w_slot_end, w_frame_done, w_clr;
   logic [15:0]      r_frame, r_map_d, r_pending;
   logic [15:0]      w_map, w_clr_bit;
   logic             w_upd, w_valid;
   logic [3:0]       w_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_s1 <= 4'hF;
         r_row_s2 <= 4'hF;
      end else begin
         r_row_s1 <= Row;
         r_row_s2 <= r_row_s1;
      end
   end

   // Row pin 3-r is key row r; pressed rows read low
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         w_rows[r] = ~r_row_s2[3-r];
      end
   end

   assign w_slot_end   = (r_cnt == CNT_LAST);
   assign w_frame_done = enable && w_slot_end && (r_col == COL3);
   assign w_clr        = ~enable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_frame <= '0;
      end else if (!enable) begin
         r_cnt   <= '0;
         r_frame <= '0;
      end else begin
         r_cnt <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
         if (r_cnt == CNT_SMP) begin
            r_frame[{r_col, 2'b00} +: 4] <= w_rows;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_col <= COL0;
      else     r_col <= w_col_nxt;
   end

   always_comb begin
      w_col_nxt   = r_col;
      w_col_drive = 4'b1111;
      if (!enable) begin
         w_col_nxt = COL0;
      end else begin
         w_col_drive = COL_PAT[r_col];
         if (w_slot_end) begin
            case (r_col)
               COL0:    w_col_nxt = COL1;
               COL1:    w_col_nxt = COL2;
               COL2:    w_col_nxt = COL3;
               default: w_col_nxt = COL0;
            endcase
         end
      end
   end

   // Park the columns for the whole reset pulse, not just after the next edge
   assign Col = rst ? 4'b1111 : w_col_drive;

   kypd_frame_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .clr        (w_clr),
      .frame_done (w_frame_done),
      .frame      (r_frame),
      .key_map    (w_map),
      .upd        (w_upd)
   );

   always_comb begin
      w_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (r_pending[i]) w_idx = 4'(i);
      end
   end

   assign w_valid   = enable && (r_pending != 16'd0);
   assign w_clr_bit = w_valid ? (16'd1 << w_idx) : 16'd0;

   // r_map_d still holds the previous map during the update cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_map_d   <= '0;
      end else if (!enable) begin
         r_pending <= '0;
         r_map_d   <= '0;
      end else begin
         r_map_d   <= w_map;
         r_pending <= (r_pending & ~w_clr_bit) | (w_upd ? (w_map & ~r_map_d) : 16'd0);
      end
   end

   assign key_valid = w_valid;
   assign key_code  = w_valid ? KEY_LEGEND[w_idx] : 4'h0;
   assign key_map   = w_map;
   assign key_down  = |w_map;

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Bench for kypd_scan_ctrl: keypad matrix model, frame-level reference model,
// table-driven single-key vectors and hand-written enable/reset sequences.
module tb_kypd_scan_ctrl;

   localparam int COL_CYC = 20;
   localparam int SETTLE  = 4;
   localparam int DB      = 2;
   localparam int FRAME   = 4 * COL_CYC;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] key_map;
   logic        key_down;

   kypd_scan_ctrl #(
      .COL_CYC         (COL_CYC),
      .SETTLE_CYC      (SETTLE),
      .DEBOUNCE_FRAMES (DB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .Row       (row),
      .Col       (col),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_map   (key_map),
      .key_down  (key_down)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk or posedge rst) begin
      if (rst || !enable) cyc <= 0;
      else                cyc <= cyc + 1;
   end

   // ---------------- keypad matrix model ----------------
   logic [3:0] pin_press [4];
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int p = 0; p < 4; p++)
            if (pin_press[c][p] && !col[3-c]) row[p] = 1'b0;
   end

   task automatic set_keys(input logic [15:0] m);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            pin_press[c][3-r] = m[c*4+r];
   endtask

   // ---------------- scoreboard ----------------
   typedef struct { int cyc; logic [3:0] code; } ev_t;
   typedef struct { int cyc; logic [15:0] map; } mp_t;
   typedef struct { int col; int pin; logic [15:0] exp_map; logic [3:0] exp_code; } vec_t;

   ev_t        exp_q[$];
   mp_t        map_q[$];
   logic [3:0] legend_rc [4][4];
   logic [3:0] col_exp [4];
   logic [15:0] frames [32];
   vec_t       tbl [16];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic       mon_on   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_cyc(input int target);
      int guard = 0;
      while (cyc != target) begin
         @(negedge clk);
         guard++;
         if (guard > 20000) begin
            n_fail++;
            $display("FAIL wait_timeout: cyc %0d never reached %0d", cyc, target);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "timeout");
         end
      end
   endtask

   // Frame-level reference: debounce rule applied to whole frames; new keys
   // issue in ascending index order starting the cycle after the update.
   task automatic build_expect(input int nf);
      logic [15:0] prev, map, fr, nw;
      int st, e, k;
      ev_t ev;
      mp_t mp;
      prev = '0; map = '0; st = 0;
      for (int f = 0; f < nf; f++) begin
         fr = frames[f];
         if (fr == prev) st = (st + 1 > DB) ? DB : st + 1;
         else            st = 1;
         prev = fr;
         if (st == DB) begin
            e = FRAME * f + FRAME;
            mp.cyc = e - 1; mp.map = map; map_q.push_back(mp);
            nw  = fr & ~map;
            map = fr;
            mp.cyc = e; mp.map = map; map_q.push_back(mp);
            k = 0;
            for (int i = 0; i < 16; i++) begin
               if (nw[i]) begin
                  ev.cyc = e + 1 + k; ev.code = legend_rc[i/4][i%4];
                  exp_q.push_back(ev);
                  k++;
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      ev_t ev;
      mp_t mp;
      if (mon_on) begin
         if ((cyc % COL_CYC) == 0 || (cyc % COL_CYC) == COL_CYC - 1)
            check("col_scan", col, col_exp[(cyc / COL_CYC) % 4]);
         if (key_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_key_valid", key_valid, 1'b0);
            end else begin
               ev = exp_q.pop_front();
               check("event_cycle", cyc, ev.cyc);
               check("event_code", key_code, ev.code);
            end
         end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               ev = exp_q.pop_front();
               check("missed_event", key_valid, 1'b1);
            end
         end
         while (map_q.size() > 0 && map_q[0].cyc <= cyc) begin
            mp = map_q.pop_front();
            if (mp.cyc == cyc) begin
               check("key_map", key_map, mp.map);
               check("key_down", key_down, |mp.map);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset(input logic [15:0] keys);
      mon_on = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; enable = 1'b1;
      set_keys(keys);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_col", col, 4'b1111);
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_key_code", key_code, 4'h0);
      check("rst_key_map", key_map, 16'h0);
      check("rst_key_down", key_down, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_frames(input int nf);
      exp_q.delete();
      map_q.delete();
      build_expect(nf);
      mon_on = 1'b1;
      for (int f = 1; f < nf; f++) begin
         wait_cyc(FRAME * f - 10);
         set_keys(frames[f]);
      end
      wait_cyc(FRAME * nf + 40);
      mon_on = 1'b0;
      check("events_left", exp_q.size(), 0);
      exp_q.delete();
      map_q.delete();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int seen, extra, nv;
      logic [15:0] m;
      rst = 1'b1; enable = 1'b0;
      set_keys(16'h0);
      legend_rc = '{'{4'h1, 4'h4, 4'h7, 4'h0}, '{4'h2, 4'h5, 4'h8, 4'hF},
                    '{4'h3, 4'h6, 4'h9, 4'hE}, '{4'hA, 4'hB, 4'hC, 4'hD}};
      col_exp = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
      tbl[0]  = '{0, 3, 16'h0001, 4'h1};  tbl[1]  = '{0, 2, 16'h0002, 4'h4};
      tbl[2]  = '{0, 1, 16'h0004, 4'h7};  tbl[3]  = '{0, 0, 16'h0008, 4'h0};
      tbl[4]  = '{1, 3, 16'h0010, 4'h2};  tbl[5]  = '{1, 2, 16'h0020, 4'h5};
      tbl[6]  = '{1, 1, 16'h0040, 4'h8};  tbl[7]  = '{1, 0, 16'h0080, 4'hF};
      tbl[8]  = '{2, 3, 16'h0100, 4'h3};  tbl[9]  = '{2, 2, 16'h0200, 4'h6};
      tbl[10] = '{2, 1, 16'h0400, 4'h9};  tbl[11] = '{2, 0, 16'h0800, 4'hE};
      tbl[12] = '{3, 3, 16'h1000, 4'hA};  tbl[13] = '{3, 2, 16'h2000, 4'hB};
      tbl[14] = '{3, 1, 16'h4000, 4'hC};  tbl[15] = '{3, 0, 16'h8000, 4'hD};

      // Idle scanning, no keys
      for (int f = 0; f < 3; f++) frames[f] = 16'h0;
      do_reset(frames[0]);
      run_frames(3);

      // Single keys by pin, one per table row
      for (int t = 0; t < 16; t++) begin
         do_reset(16'h0);
         pin_press[tbl[t].col][tbl[t].pin] = 1'b1;
         seen = -1;
         for (int k = 0; k < 300 && seen < 0; k++) begin
            @(negedge clk);
            if (key_valid) seen = cyc;
         end
         check("single_evt_cycle", seen, 161);
         check("single_code", key_code, tbl[t].exp_code);
         @(negedge clk);
         check("single_map", key_map, tbl[t].exp_map);
         check("single_down", key_down, 1'b1);
         extra = 0;
         while (cyc < 270) begin @(negedge clk); if (key_valid) extra++; end
         set_keys(16'h0);
         while (cyc < 500) begin @(negedge clk); if (key_valid) extra++; end
         check("single_extra_events", extra, 0);
         check("release_map", key_map, 16'h0);
         check("release_down", key_down, 1'b0);
      end

      // Bounce: key 5 toggles for 4 frames, then holds
      frames[0] = 16'h0;
      for (int f = 1; f < 5; f++) frames[f] = (f % 2) ? 16'h0020 : 16'h0000;
      for (int f = 5; f < 9; f++) frames[f] = 16'h0020;
      do_reset(frames[0]);
      run_frames(9);

      // Multi-key: 1, A, D in one frame
      frames[0] = 16'h0;
      for (int f = 1; f < 4; f++) frames[f] = 16'h9001;
      do_reset(frames[0]);
      run_frames(4);

      // Random frames against the reference model
      frames[0] = 16'h0;
      for (int f = 1; f < 30; f++) begin
         if ($urandom_range(0, 1) == 1) frames[f] = frames[f-1];
         else begin
            m = '0;
            repeat ($urandom_range(0, 3)) m[$urandom_range(0, 15)] = 1'b1;
            frames[f] = m;
         end
      end
      do_reset(frames[0]);
      run_frames(30);

      // Enable drop in the map-update cycle of a three-key press
      do_reset(16'h0421);
      wait_cyc(159);
      check("pre_drop_map", key_map, 16'h0);
      @(posedge clk); #1;
      enable = 1'b0;
      @(negedge clk);
      check("drop_col", col, 4'b1111);
      check("drop_valid", key_valid, 1'b0);
      nv = 0;
      repeat (10) begin @(negedge clk); if (key_valid) nv++; end
      check("drop_no_events", nv, 0);
      check("drop_map", key_map, 16'h0);
      check("drop_down", key_down, 1'b0);
      check("drop_col_held", col, 4'b1111);
      set_keys(16'h0);
      exp_q.delete();
      map_q.delete();
      @(posedge clk); #1;
      enable = 1'b1;
      mon_on = 1'b1;
      @(negedge clk);
      check("reenable_col", col, 4'b0111);
      wait_cyc(90);
      mon_on = 1'b0;
      check("reenable_map", key_map, 16'h0);

      // Asynchronous reset at cnt=7 of col2
      do_reset(16'h0040);
      wait_cyc(2 * FRAME + 2 * COL_CYC + 7);
      check("pre_rst_map", key_map, 16'h0040);
      check("pre_rst_col", col, 4'b1101);
      #2 rst = 1'b1;
      #1;
      check("async_col", col, 4'b1111);
      check("async_valid", key_valid, 1'b0);
      check("async_code", key_code, 4'h0);
      check("async_map", key_map, 16'h0);
      check("async_down", key_down, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("restart_col0", col, 4'b0111);
      wait_cyc(COL_CYC);
      check("restart_col1", col, 4'b1011);
      check("restart_map", key_map, 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
